wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-port arbiter for the RV32IM register file. The integer pipeline's writeback stage and the multi-cycle MUL/DIV unit both produce results, but the register file has one write port. This block shares that port between them. It buffers MUL/DIV results in a small FIFO, gives the pipeline priority with a bounded starvation limit, and exports a pending-destination mask for hazard detection.

## Interface
Parameters:
- XLEN, 32, data width
- DEPTH, 2, MUL/DIV result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO head may wait before it is forced through

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pipe_valid  in  1  pipeline writeback request
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  XLEN  pipeline result
- pipe_stall  out  1  pipeline must hold its writeback request this cycle
- md_valid  in  1  MUL/DIV result valid
- md_ready  out  1  arbiter can accept a MUL/DIV result
- md_rd  in  5  MUL/DIV destination
- md_data  in  XLEN  MUL/DIV result
- write_register  out  5  register file write address
- write_data  out  XLEN  register file write data
- reg_write  out  1  register file write enable
- pending_mask  out  32  bit i set while a buffered MUL/DIV result targets x(i)
- fifo_count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Pipeline acceptance:
  - Accepted when pipe_valid=1 and pipe_stall=0.
  - Accepted with pipe_rd≠0: it owns the write port this cycle.
  - Accepted with pipe_rd=0: dropped; it does not consume the port.
- MUL/DIV acceptance:
  - md_ready = !full, from registered count only; there is no same-cycle pop bypass.
  - Accepted on md_valid&md_ready.
  - md_rd=0: accepted and discarded, not enqueued.
- FSM states:
  - NORMAL:
    - pipe_stall=0.
    - The FIFO head pops only if the FIFO is non-empty and the pipeline does not own the port.
    - starve_cnt increments each cycle the FIFO is non-empty and does not pop. It clears on pop or when the FIFO is empty.
    - starve_cnt==STARVE_LIMIT-1 and no pop this cycle → FORCE.
  - FORCE:
    - pipe_stall=1 (decoded from the state register, not combinational from inputs).
    - pipe_valid is ignored.
    - The head pops, starve_cnt clears, and the next state is NORMAL.
    - FORCE lasts exactly one cycle.
- Grant registration:
  - The granted source registers into write_register/write_data/reg_write.
  - With no grant, reg_write=0, and write_register/write_data hold their previous values.
- pending_mask: OR of one-hot decodes of md_rd over the valid FIFO entries. It is combinational from FIFO state, so duplicate rd entries keep the bit set until the last one pops.
- FIFO pointer handling:
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
  - A push when full cannot occur, because md_ready=0.
- Ordering: MUL/DIV results write in FIFO order. Pipeline and MUL/DIV writes to the same rd resolve in grant order; WAW hazards are the issue stage's job, using pending_mask.

## Timing
- Reset values:
  - reg_write=0, write_register=0, write_data=0.
  - pipe_stall=0.
  - md_ready=1.
  - pending_mask=0, fifo_count=0.
  - State NORMAL, starve_cnt=0.
- Reset mid-operation: FIFO contents are discarded, with no write issued for them.
- Pipeline write latency: a pipeline request granted in cycle N appears on reg_write from the edge ending cycle N.
- MUL/DIV write latency:
  - Result accepted in cycle N enqueues at the end of N.
  - Earliest pop is cycle N+1; reg_write follows at the end of N+1.
- Worst-case head wait: STARVE_LIMIT cycles in NORMAL plus one FORCE cycle.
- pending_mask bit behaviour:
  - Sets the cycle after enqueue.
  - Clears the cycle after pop, the same edge that raises reg_write for that entry.

## Structure
- wb_pkg holds:
  - the FSM state enum (ARB_NORMAL, ARB_FORCE);
  - the wb_req_t struct {rd, data};
  - the REG_ZERO constant.
- One sub-module, wb_fifo: DEPTH-entry synchronous FIFO of wb_req_t with async active-high reset. It exposes full, empty, count and a valid-entry vector for the pending_mask decode.
- The arbiter top holds the FSM, starve counter, grant mux and output registers.

## Test plan
- Reset mid-stream:
  - Stimulus: assert reset with 2 entries buffered.
  - Required: outputs go to reset values immediately; no write of the buffered data occurs after release.
- Idle drain:
  - Stimulus: pipe_valid=0; md result rd=5, data=0x0000_0042 accepted at cycle 0.
  - Required: pending_mask=0x20 at cycle 1; reg_write=1, write_register=5, write_data=0x42 after cycle 1.
  - Required: pending_mask=0 at the same edge.
- Priority and starvation:
  - Stimulus: pipe_valid=1, rd=3 every cycle; one md entry rd=7.
  - Required: the pipeline writes x3 for 4 cycles, then pipe_stall=1 for exactly one cycle and x7 is written.
  - Required: pipeline writes then resume.
- Full FIFO:
  - Stimulus: pipeline saturated; 3 back-to-back md results.
  - Required: md_ready drops after 2 are accepted, fifo_count=2, and the third result is held until a pop.
  - Required: FIFO order is preserved on drain.
- x0 handling:
  - Stimulus: pipe rd=0 and md rd=0 requests.
  - Required: reg_write stays 0 and pending_mask stays 0.
  - Stimulus: pipe rd=0 with a buffered entry.
  - Required: that entry drains in the same cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Queued MUL/DIV requests carry an RV32 word.
package wb_pkg;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

  localparam int WB_XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO of MUL/DIV writeback requests.
// Exposes per-entry valid bits and destinations so the owner can build a hazard mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  wb_req_t                push_req_i,
  input  logic                   pop_i,
  output wb_req_t                head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DEPTH-1:0]       valid_o,
  output logic [DEPTH*5-1:0]     entry_rd_o
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t          mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic [DEPTH-1:0] valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset: valid_q gates every consumer of the storage.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_req_i;
  end

  // Push and pop never target the same slot: that needs a full or empty FIFO.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q[gi] <= 1'b0;
      end else if (push_i && (wr_ptr_q == PW'(gi))) begin
        valid_q[gi] <= 1'b1;
      end else if (pop_i && (rd_ptr_q == PW'(gi))) begin
        valid_q[gi] <= 1'b0;
      end
    end
    assign entry_rd_o[gi*5 +: 5] = mem_q[gi].rd;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/wb_arbiter.sv
// Shares the register-file write port between the pipeline writeback stage and
// buffered MUL/DIV results; the pipeline wins unless the FIFO head has starved.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pipe_valid,
  input  logic [4:0]             pipe_rd,
  input  logic [XLEN-1:0]        pipe_data,
  output logic                   pipe_stall,
  input  logic                   md_valid,
  output logic                   md_ready,
  input  logic [4:0]             md_rd,
  input  logic [XLEN-1:0]        md_data,
  output logic [4:0]             write_register,
  output logic [XLEN-1:0]        write_data,
  output logic                   reg_write,
  output logic [31:0]            pending_mask,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              reg_write_q, reg_write_d;
  logic [4:0]        write_register_q, write_register_d;
  logic [XLEN-1:0]   write_data_q, write_data_d;

  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  wb_req_t           fifo_head, push_req;
  logic [DEPTH-1:0]  fifo_valid;
  logic [DEPTH*5-1:0] fifo_entry_rd;
  logic              pipe_own;
  logic [31:0]       entry_mask [DEPTH];
  logic [31:0]       pending_c;

  // Acceptance of a zero-destination MUL/DIV result still completes the handshake.
  assign md_ready  = !fifo_full;
  assign fifo_push = md_valid && md_ready && (md_rd != REG_ZERO);
  assign push_req  = '{rd: md_rd, data: WB_XLEN'(md_data)};
  assign pipe_own  = pipe_valid && (state_q == ARB_NORMAL) && (pipe_rd != REG_ZERO);

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .push_i     (fifo_push),
    .push_req_i (push_req),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .valid_o    (fifo_valid),
    .entry_rd_o (fifo_entry_rd)
  );

  always_comb begin
    state_d          = state_q;
    starve_d         = starve_q;
    fifo_pop         = 1'b0;
    reg_write_d      = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;

    case (state_q)
      ARB_NORMAL: begin
        fifo_pop = !fifo_empty && !pipe_own;
        if (fifo_empty || fifo_pop) begin
          starve_d = '0;
        end else if (starve_q == CW'(STARVE_LIMIT - 1)) begin
          state_d  = ARB_FORCE;
          starve_d = '0;
        end else begin
          starve_d = starve_q + 1'b1;
        end
      end
      ARB_FORCE: begin
        fifo_pop = !fifo_empty;
        starve_d = '0;
        state_d  = ARB_NORMAL;
      end
      default: begin
        state_d  = ARB_NORMAL;
        starve_d = '0;
      end
    endcase

    if (pipe_own) begin
      reg_write_d      = 1'b1;
      write_register_d = pipe_rd;
      write_data_d     = pipe_data;
    end else if (fifo_pop) begin
      reg_write_d      = 1'b1;
      write_register_d = fifo_head.rd;
      write_data_d     = XLEN'(fifo_head.data);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ARB_NORMAL;
      starve_q         <= '0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
    end else begin
      state_q          <= state_d;
      starve_q         <= starve_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end

  // Duplicate destinations OR together, so a bit stays up until its last entry pops.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pending
    assign entry_mask[gi] = fifo_valid[gi] ? (32'd1 << fifo_entry_rd[gi*5 +: 5]) : 32'd0;
  end

  always_comb begin
    pending_c = 32'd0;
    for (int i = 0; i < DEPTH; i++) pending_c = pending_c | entry_mask[i];
  end

  assign pending_mask   = pending_c;
  assign pipe_stall     = (state_q == ARB_FORCE);
  assign reg_write      = reg_write_q;
  assign write_register = write_register_q;
  assign write_data     = write_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, drain, starvation, full FIFO, x0 and mid-stream reset.
module tb_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] pending_mask;
  logic [1:0]  fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .pipe_valid     (pipe_valid),
    .pipe_rd        (pipe_rd),
    .pipe_data      (pipe_data),
    .pipe_stall     (pipe_stall),
    .md_valid       (md_valid),
    .md_ready       (md_ready),
    .md_rd          (md_rd),
    .md_data        (md_data),
    .write_register (write_register),
    .write_data     (write_data),
    .reg_write      (reg_write),
    .pending_mask   (pending_mask),
    .fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pipe_valid = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    tick(); tick();
    n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL rst_reg_write got %b want 0", reg_write); end
    n_cmp++; if (write_register !== 5'd0) begin n_err++; $display("FAIL rst_write_register got %0d want 0", write_register); end
    n_cmp++; if (write_data !== 32'd0) begin n_err++; $display("FAIL rst_write_data got %h want 0", write_data); end
    n_cmp++; if (pipe_stall !== 1'b0) begin n_err++; $display("FAIL rst_pipe_stall got %b want 0", pipe_stall); end
    n_cmp++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL rst_md_ready got %b want 1", md_ready); end
    n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL rst_pending got %h want 0", pending_mask); end
    n_cmp++; if (fifo_count !== 2'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", fifo_count); end
    $display("[reset] outputs sampled under reset");
    reset = 1'b0;
  endtask

  task automatic test_idle_drain();
    md_valid = 1'b1; md_rd = 5'd5; md_data = 32'h0000_0042;
    tick();
    md_valid = 1'b0;
    n_cmp++; if (pending_mask !== 32'h20) begin n_err++; $display("FAIL drain_pending_set got %h want 20", pending_mask); end
    n_cmp++; if (fifo_count !== 2'd1) begin n_err++; $display("FAIL drain_count got %0d want 1", fifo_count); end
    n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL drain_no_early_write got %b want 0", reg_write); end
    tick();
    n_cmp++; if (reg_write !== 1'b1) begin n_err++; $display("FAIL drain_reg_write got %b want 1", reg_write); end
    n_cmp++; if (write_register !== 5'd5) begin n_err++; $display("FAIL drain_rd got %0d want 5", write_register); end
    n_cmp++; if (write_data !== 32'h42) begin n_err++; $display("FAIL drain_data got %h want 42", write_data); end
    n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL drain_pending_clr got %h want 0", pending_mask); end
    $display("[drain] write x%0d = %h", write_register, write_data);
    tick();
    n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL drain_idle_we got %b want 0", reg_write); end
    n_cmp++; if (write_register !== 5'd5) begin n_err++; $display("FAIL drain_hold_rd got %0d want 5", write_register); end
  endtask

  task automatic test_starvation();
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h0000_0300;
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h0000_0077;
    tick();
    md_valid = 1'b0;
    n_cmp++; if (pending_mask !== 32'h80) begin n_err++; $display("FAIL starve_pending got %h want 80", pending_mask); end
    for (int i = 0; i < 4; i++) begin
      pipe_data = 32'h0000_0301 + i;
      tick();
      n_cmp++; if (reg_write !== 1'b1 || write_register !== 5'd3 || write_data !== 32'h0000_0301 + i) begin
        n_err++; $display("FAIL starve_pipe_write%0d got we=%b rd=%0d data=%h want we=1 rd=3 data=%h", i, reg_write, write_register, write_data, 32'h0000_0301 + i);
      end
      n_cmp++; if (pipe_stall !== (i == 3)) begin n_err++; $display("FAIL starve_stall%0d got %b want %b", i, pipe_stall, (i == 3)); end
      $display("[starve] cycle %0d write x%0d stall=%b", i, write_register, pipe_stall);
    end
    pipe_data = 32'h0000_0DEAD;
    tick();
    n_cmp++; if (write_register !== 5'd7 || write_data !== 32'h77 || reg_write !== 1'b1) begin
      n_err++; $display("FAIL starve_force_write got we=%b rd=%0d data=%h want we=1 rd=7 data=77", reg_write, write_register, write_data);
    end
    n_cmp++; if (pipe_stall !== 1'b0) begin n_err++; $display("FAIL starve_stall_one got %b want 0", pipe_stall); end
    n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL starve_pending_clr got %h want 0", pending_mask); end
    pipe_data = 32'h0000_0310;
    tick();
    n_cmp++; if (write_register !== 5'd3 || write_data !== 32'h310) begin
      n_err++; $display("FAIL starve_resume got rd=%0d data=%h want rd=3 data=310", write_register, write_data);
    end
  endtask

  task automatic test_full_fifo();
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h0000_0400;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h0000_00A1;
    tick();
    n_cmp++; if (fifo_count !== 2'd1 || md_ready !== 1'b1) begin n_err++; $display("FAIL full_first got count=%0d ready=%b want 1/1", fifo_count, md_ready); end
    md_rd = 5'd10; md_data = 32'h0000_00B2;
    tick();
    n_cmp++; if (fifo_count !== 2'd2 || md_ready !== 1'b0) begin n_err++; $display("FAIL full_second got count=%0d ready=%b want 2/0", fifo_count, md_ready); end
    n_cmp++; if (pending_mask !== 32'h0000_0600) begin n_err++; $display("FAIL full_pending got %h want 600", pending_mask); end
    md_rd = 5'd11; md_data = 32'h0000_00C3;
    tick();
    n_cmp++; if (fifo_count !== 2'd2 || md_ready !== 1'b0) begin n_err++; $display("FAIL full_held got count=%0d ready=%b want 2/0", fifo_count, md_ready); end
    tick(); tick();
    n_cmp++; if (pipe_stall !== 1'b1) begin n_err++; $display("FAIL full_force got %b want 1", pipe_stall); end
    tick();
    n_cmp++; if (write_register !== 5'd9 || write_data !== 32'hA1) begin n_err++; $display("FAIL full_pop_a got rd=%0d data=%h want 9/a1", write_register, write_data); end
    n_cmp++; if (fifo_count !== 2'd1 || md_ready !== 1'b1) begin n_err++; $display("FAIL full_after_pop got count=%0d ready=%b want 1/1", fifo_count, md_ready); end
    tick();
    md_valid = 1'b0; pipe_valid = 1'b0;
    n_cmp++; if (fifo_count !== 2'd2 || write_register !== 5'd3) begin n_err++; $display("FAIL full_third_in got count=%0d rd=%0d want 2/3", fifo_count, write_register); end
    tick();
    n_cmp++; if (write_register !== 5'd10 || write_data !== 32'hB2) begin n_err++; $display("FAIL full_pop_b got rd=%0d data=%h want 10/b2", write_register, write_data); end
    tick();
    n_cmp++; if (write_register !== 5'd11 || write_data !== 32'hC3 || fifo_count !== 2'd0) begin
      n_err++; $display("FAIL full_pop_c got rd=%0d data=%h count=%0d want 11/c3/0", write_register, write_data, fifo_count);
    end
    $display("[full] drained in order, last x%0d", write_register);
  endtask

  task automatic test_x0();
    tick();
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h0000_0BAD;
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h0000_0BAD;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL x0_we%0d got %b want 0", i, reg_write); end
      n_cmp++; if (pending_mask !== 32'd0 || fifo_count !== 2'd0) begin n_err++; $display("FAIL x0_pending%0d got %h/%0d want 0/0", i, pending_mask, fifo_count); end
    end
    pipe_rd = 5'd3; pipe_data = 32'h0000_0500;
    md_rd = 5'd12; md_data = 32'h0000_00CC;
    tick();
    md_valid = 1'b0; pipe_rd = 5'd0;
    n_cmp++; if (write_register !== 5'd3 || fifo_count !== 2'd1) begin n_err++; $display("FAIL x0_setup got rd=%0d count=%0d want 3/1", write_register, fifo_count); end
    tick();
    n_cmp++; if (reg_write !== 1'b1 || write_register !== 5'd12 || write_data !== 32'hCC) begin
      n_err++; $display("FAIL x0_drain got we=%b rd=%0d data=%h want 1/12/cc", reg_write, write_register, write_data);
    end
    pipe_valid = 1'b0;
    $display("[x0] buffered x%0d drained beside x0 request", write_register);
  endtask

  task automatic test_reset_midstream();
    tick();
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h0000_0600;
    md_valid = 1'b1; md_rd = 5'd13; md_data = 32'h0000_00D4;
    tick();
    md_rd = 5'd14; md_data = 32'h0000_00E5;
    tick();
    md_valid = 1'b0;
    n_cmp++; if (fifo_count !== 2'd2) begin n_err++; $display("FAIL mid_prefill got %0d want 2", fifo_count); end
    reset = 1'b1;
    #1;
    n_cmp++; if (reg_write !== 1'b0 || write_register !== 5'd0 || write_data !== 32'd0) begin
      n_err++; $display("FAIL mid_outputs got we=%b rd=%0d data=%h want 0/0/0", reg_write, write_register, write_data);
    end
    n_cmp++; if (fifo_count !== 2'd0 || pending_mask !== 32'd0 || md_ready !== 1'b1 || pipe_stall !== 1'b0) begin
      n_err++; $display("FAIL mid_state got count=%0d pend=%h ready=%b stall=%b want 0/0/1/0", fifo_count, pending_mask, md_ready, pipe_stall);
    end
    pipe_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL mid_no_write%0d got %b want 0 (rd=%0d)", i, reg_write, write_register); end
    end
    $display("[midrst] buffered entries discarded");
  endtask

  initial begin
    test_reset();
    test_idle_drain();
    test_starvation();
    test_full_fifo();
    test_x0();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
